// File: rtl/seq_scan_ctrl.sv
// Run controller for a 4-bit sequence detector: gates a fixed window of stream bits into the detector and counts its match pulses.
// Latency: a window of L bits gives done in cycle L+DRAIN_CYC+1 after accept; cfg_len=0 gives done in cycle 1.
// Backpressure: s_ready is high for every RUN slot, and a missing s_valid is consumed as a 0 bit and flagged, because the detector cannot stall.
module seq_scan_ctrl #(
    parameter int CW        = 8,
    parameter int LW        = 16,
    parameter int DRAIN_CYC = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [3:0]    cfg_seq,
    input  logic [LW-1:0] cfg_len,
    input  logic          abort,
    input  logic          s_valid,
    input  logic          s_data,
    output logic          s_ready,
    output logic          det_reset,
    output logic [3:0]    det_seq,
    output logic          det_in,
    input  logic          det_out,
    output logic          done,
    output logic [CW-1:0] match_cnt,
    output logic          sat,
    output logic          err_underrun,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [LW-1:0] len_q;
    logic [LW-1:0] bit_cnt;
    logic [3:0]    drain_cnt;
    logic          last_slot;
    logic          drain_last;
    logic          sample;
    logic [CW-1:0] cnt_inc;

    // bit_cnt holds the index of the current RUN slot, so it never exceeds cfg_len.
    assign last_slot  = (bit_cnt == len_q - LW'(1));
    assign drain_last = (drain_cnt == 4'(DRAIN_CYC - 1));
    // Slot 0 is skipped: the detector flag can be left over from before its reset released.
    assign sample     = ((state_q == RUN) && (bit_cnt != '0)) || (state_q == DRAIN);
    assign cnt_inc    = match_cnt + CW'(1);

    // Handshake and detector controls decoded straight from the state register.
    assign cfg_ready = (state_q == IDLE);
    assign s_ready   = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign det_reset = (state_q == IDLE) || (state_q == DONE);
    assign det_in    = (state_q == RUN) && s_valid && s_data;

    // Next-state logic: abort wins over the normal RUN/DRAIN progression.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_valid) state_d = (cfg_len != '0) ? RUN : DONE;
            RUN:     if (abort) state_d = IDLE;
                     else if (last_slot) state_d = DRAIN;
            DRAIN:   if (abort) state_d = IDLE;
                     else if (drain_last) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // State register plus request capture, slot/drain counters and result accumulation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            bit_cnt      <= '0;
            drain_cnt    <= '0;
            det_seq      <= '0;
            match_cnt    <= '0;
            sat          <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && cfg_valid) begin
                det_seq      <= cfg_seq;
                len_q        <= cfg_len;
                bit_cnt      <= '0;
                match_cnt    <= '0;
                sat          <= 1'b0;
                err_underrun <= 1'b0;
            end
            if (state_q == RUN) begin
                bit_cnt   <= bit_cnt + LW'(1);
                drain_cnt <= '0;
                if (!s_valid) err_underrun <= 1'b1;
            end
            if (state_q == DRAIN) drain_cnt <= drain_cnt + 4'd1;
            // Saturating count: holds at all-ones with sat set.
            if (sample && det_out && !(&match_cnt)) begin
                match_cnt <= cnt_inc;
                sat       <= &cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: per-cycle handshake/timeline checks for each scan plus result checks.
// A second instance with CW=3 shares all stimulus and exercises counter saturation.
// Inputs change 1 time unit after the rising edge; outputs are checked mid-cycle.
module tb_seq_scan_ctrl;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic [3:0]  cfg_seq;
    logic [15:0] cfg_len;
    logic        abort;
    logic        s_valid;
    logic        s_data;
    logic        det_out;

    logic        cfg_ready, s_ready, det_reset, det_in, done, sat, err_underrun, busy;
    logic [3:0]  det_seq;
    logic [7:0]  match_cnt;

    logic        x_cfg_ready, x_s_ready, x_det_reset, x_det_in, x_done, x_sat, x_err, x_busy;
    logic [3:0]  x_det_seq;
    logic [2:0]  x_match_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    seq_scan_ctrl #(.CW(8), .LW(16), .DRAIN_CYC(D)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_seq(cfg_seq), .cfg_len(cfg_len), .abort(abort), .s_valid(s_valid),
        .s_data(s_data), .s_ready(s_ready), .det_reset(det_reset), .det_seq(det_seq),
        .det_in(det_in), .det_out(det_out), .done(done), .match_cnt(match_cnt),
        .sat(sat), .err_underrun(err_underrun), .busy(busy)
    );

    seq_scan_ctrl #(.CW(3), .LW(16), .DRAIN_CYC(D)) dut_s (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(x_cfg_ready),
        .cfg_seq(cfg_seq), .cfg_len(cfg_len), .abort(abort), .s_valid(s_valid),
        .s_data(s_data), .s_ready(x_s_ready), .det_reset(x_det_reset), .det_seq(x_det_seq),
        .det_in(x_det_in), .det_out(det_out), .done(x_done), .match_cnt(x_match_cnt),
        .sat(x_sat), .err_underrun(x_err), .busy(x_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cfg_ready"}, cfg_ready, 1);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_det_reset"}, det_reset, 1);
        chk({tag, "_det_seq"}, det_seq, 0);
        chk({tag, "_det_in"}, det_in, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_match_cnt"}, match_cnt, 0);
        chk({tag, "_sat"}, sat, 0);
        chk({tag, "_err"}, err_underrun, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // One scan: ufl = cycle with s_valid low (0 = none), abt = cycle with abort (0 = none),
    // dmask bit c = det_out level in cycle c after the accept edge.
    task automatic scan(input string tag, input logic [3:0] seq, input int len,
                        input logic [63:0] dmask, input int ufl, input int abt,
                        input int ncyc, input int exp_cnt, input logic exp_err);
        int st;
        chk({tag, "_ready_c0"}, cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_seq   = seq;
        cfg_len   = 16'(len);
        step();
        cfg_valid = 1'b0;
        cfg_seq   = 4'd0;
        cfg_len   = 16'd0;
        for (int c = 1; c <= ncyc; c++) begin
            // expected state: 0 IDLE, 1 RUN, 2 DRAIN, 3 DONE
            if (abt != 0 && c > abt)  st = 0;
            else if (len == 0)        st = (c == 1) ? 3 : 0;
            else if (c <= len)        st = 1;
            else if (c <= len + D)    st = 2;
            else if (c == len + D + 1) st = 3;
            else                      st = 0;
            s_valid = (c != ufl);
            s_data  = (c == ufl) ? 1'b1 : (c[0] ^ c[1]);
            det_out = dmask[c];
            abort   = (c == abt);
            #1;
            chk({tag, "_cfg_ready"}, cfg_ready, (st == 0));
            chk({tag, "_s_ready"}, s_ready, (st == 1));
            chk({tag, "_done"}, done, (st == 3));
            chk({tag, "_det_reset"}, det_reset, (st == 0 || st == 3));
            chk({tag, "_busy"}, busy, (st != 0));
            chk({tag, "_det_in"}, det_in, (st == 1) && s_valid && s_data);
            if (st != 0) chk({tag, "_det_seq"}, det_seq, seq);
            if (st == 3) begin
                chk({tag, "_match_cnt"}, match_cnt, exp_cnt);
                chk({tag, "_err"}, err_underrun, exp_err);
            end
            step();
        end
        s_valid = 1'b0;
        s_data  = 1'b0;
        det_out = 1'b0;
        abort   = 1'b0;
        #1;
        chk({tag, "_hold_cnt"}, match_cnt, exp_cnt);
        chk({tag, "_hold_err"}, err_underrun, exp_err);
    endtask

    initial begin
        reset = 1'b0; cfg_valid = 1'b0; cfg_seq = 4'd0; cfg_len = 16'd0;
        abort = 1'b0; s_valid = 1'b0; s_data = 1'b0; det_out = 1'b0;
        repeat (3) step();
        chk_reset_vals("rst");
        reset = 1'b1;
        step();

        // det_out in RUN slots 3 and 6 (cycles 4, 7) and DRAIN cycle 9
        scan("nom", 4'b1011, 8, (64'd1 << 4) | (64'd1 << 7) | (64'd1 << 9), 0, 0, 12, 3, 1'b0);
        // det_out only in slot 0 (cycle 1): must not count
        scan("slot0", 4'b0110, 4, 64'd1 << 1, 0, 0, 8, 0, 1'b0);
        // s_valid low in slot 2 (cycle 3)
        scan("ufl", 4'b1100, 6, 64'd0, 3, 0, 10, 0, 1'b1);
        // det_out held high: 19 RUN samples + 2 DRAIN samples = 21
        scan("satw", 4'b1111, 20, {64{1'b1}}, 0, 0, 24, 21, 1'b0);
        chk("sat_dut8", sat, 0);
        chk("sat_cnt3", x_match_cnt, 7);
        chk("sat_flag3", x_sat, 1);
        // zero-length request clears the previous 21
        scan("zero", 4'b0001, 0, 64'd0, 0, 0, 3, 0, 1'b0);
        chk("zero_sat3", x_sat, 0);
        // abort in slot 4 (cycle 5); one match counted before it in cycle 3
        scan("abt", 4'b1010, 10, 64'd1 << 3, 0, 5, 14, 1, 1'b0);

        // reset during DRAIN of a len=5 scan (DRAIN is cycles 6..7)
        cfg_valid = 1'b1; cfg_seq = 4'b0101; cfg_len = 16'd5;
        step();
        cfg_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            s_valid = (c != 2);
            s_data  = 1'b1;
            det_out = (c == 3);
            if (c == 6) begin
                s_valid = 1'b0;
                reset   = 1'b0;
                #1;
                chk("mid_busy_pre", busy, 1);
                chk("mid_cnt_pre", match_cnt, 1);
                chk("mid_err_pre", err_underrun, 1);
            end
            step();
        end
        reset   = 1'b1;
        det_out = 1'b0;
        s_data  = 1'b0;
        #1;
        chk_reset_vals("mid");
        step();
        chk("mid_done_after", done, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Run controller for the programmable 4-bit sequence detector. It takes one scan request on a config handshake: a pattern, plus a window length in bits. It holds the detector in reset while idle, then gates exactly that many stream bits into the detector and counts its match pulses, including a drain tail for detector latency. It reports the final count with a one-cycle `done` pulse, and sits between the stream source and the detector, which has no enable.

## Interface
- `CW`, 8: match counter width.
- `LW`, 16: window length width.
- `DRAIN_CYC`, 2: cycles `det_out` is still sampled after the last bit (1..15).
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-low. All state is cleared on the rising edge of `clk` while `reset` = 0.
- `cfg_valid` input 1: scan request valid.
- `cfg_ready` output 1: high only in IDLE.
- `cfg_seq` input 4: pattern, MSB first, captured on accept.
- `cfg_len` input LW: number of stream bits in the window, captured on accept.
- `abort` input 1: cancels a scan in progress.
- `s_valid` input 1: stream bit valid.
- `s_data` input 1: stream bit.
- `s_ready` output 1: high only in RUN.
- `det_reset` output 1: detector reset, active-high.
- `det_seq` output 4: registered pattern to the detector.
- `det_in` output 1: bit to the detector.
- `det_out` input 1: detector match flag.
- `done` output 1: one-cycle completion pulse.
- `match_cnt` output CW: matches counted in the last scan.
- `sat` output 1: `match_cnt` saturated.
- `err_underrun` output 1: `s_valid` was low during RUN.
- `busy` output 1: state is not IDLE.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE (2-bit encoding).
- **IDLE:**
  - Outputs: `cfg_ready`=1, `det_reset`=1.
  - Accept on `cfg_valid`&`cfg_ready`: latch `cfg_seq` into `det_seq`, latch `cfg_len`, clear `match_cnt`/`sat`/`err_underrun`, clear the bit counter.
  - Next state: RUN if `cfg_len`≠0, else DONE.
- **RUN:**
  - Outputs: `det_reset`=0, `s_ready`=1, `det_in` = `s_data` (combinational); `det_in`=0 in every other state.
  - Each cycle consumes one bit slot and increments the bit counter.
  - If `s_valid`=0 in any RUN cycle: set sticky `err_underrun`, drive `det_in`=0 for that slot, and still consume the slot. The detector cannot stall.
  - After slot `cfg_len`-1, go to DRAIN.
- **DRAIN:**
  - `det_reset`=0, `det_in`=0.
  - Lasts exactly `DRAIN_CYC` cycles, then goes to DONE.
- **DONE:**
  - `done`=1 for one cycle, `det_reset`=1, then IDLE.
- **Match counting:**
  - `det_out` is sampled in RUN slot 1 onward and in every DRAIN cycle.
  - RUN slot 0 is ignored because the detector's flag is not cleared by its reset.
  - Each sampled high cycle increments `match_cnt`.
  - At all-ones the counter holds and `sat`=1.
- **abort:**
  - In RUN or DRAIN: go to IDLE next cycle, no `done`, results left as-is (partial).
  - Ignored in IDLE and DONE.
- **Priority:** `reset` > `abort` > normal transitions.
- **Results:** `match_cnt`, `sat` and `err_underrun` hold after DONE until the next accept.
- **Window length:** `cfg_len` width rules are unsigned. Maximum window is 2^LW-1 bits; the bit counter never wraps.

## Timing
- **Reset values:**
  - state IDLE, `cfg_ready`=1, `s_ready`=0, `det_reset`=1, `det_seq`=0, `det_in`=0.
  - `done`=0, `match_cnt`=0, `sat`=0, `err_underrun`=0, `busy`=0.
- **Scan timeline:** accept at edge E0, then:
  - RUN occupies cycles 1..L.
  - DRAIN occupies cycles L+1..L+`DRAIN_CYC`.
  - `done` is high in cycle L+`DRAIN_CYC`+1.
  - `cfg_ready` is high again in cycle L+`DRAIN_CYC`+2.
- **Zero-length scan:** `cfg_len`=0 gives `done` in cycle 1 with `match_cnt`=0.
- **Handshake rules:**
  - `cfg_ready` is 0 from the accept edge until IDLE is re-entered; back-to-back requests are spaced by at least one IDLE cycle.
  - `s_ready` is high for exactly L cycles per scan.
- **Register/combinational split:**
  - `det_seq` is stable from cycle 1 through DONE.
  - `busy`, `cfg_ready`, `s_ready`, `det_reset` and `done` are decoded from the state register.
- **Reset mid-scan:** next cycle is IDLE with all outputs at reset values, and no `done`.

## Test plan
- **Nominal scan:** `cfg_seq`=4'b1011, `cfg_len`=8, `s_valid` always 1, bench pulses `det_out` in RUN slots 3 and 6 and DRAIN cycle 1 -> `done` in cycle 11, `match_cnt`=3, `err_underrun`=0, `det_seq`=4'b1011 during cycles 1-10.
- **Slot-0 mask:** `cfg_len`=4, `det_out`=1 only in RUN slot 0 -> `match_cnt`=0, `done` in cycle 7.
- **Underrun:** `cfg_len`=6, `s_valid`=0 in slot 2 -> `det_in`=0 that cycle, `s_ready` still high 6 cycles, `err_underrun`=1 at `done` (cycle 9).
- **Saturation:** `CW`=3, `cfg_len`=20, `det_out` held 1 -> `match_cnt`=7, `sat`=1.
- **Abort:** abort in RUN slot 4 of a `cfg_len`=10 scan -> IDLE next cycle, `done` never asserts, `cfg_ready`=1.
- **Zero length, then reset mid-scan:** `cfg_len`=0 -> `done` in cycle 1, `match_cnt`=0. Then `reset`=0 during DRAIN -> IDLE next cycle with all outputs at reset values.
